// File: rtl/sequence_detector.sv
// Mealy detector for the serial pattern 0 1 0* 1, with a two-digit BCD count of detections
// shown on two active-low 7-segment digits.
module sequence_detector (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       sig_to_test,
  output logic [6:0] disp0,
  output logic [6:0] disp1,
  output logic       z
);

  typedef enum logic [1:0] {S0 = 2'd0, S1 = 2'd1, S2 = 2'd2, S3 = 2'd3} state_t;

  state_t     state_r;
  state_t     state_next_s;
  logic [3:0] ones_r;
  logic [3:0] tens_r;

  // Active-low segments in {g,f,e,d,c,b,a} order; non-BCD codes blank the digit
  function automatic logic [6:0] seg7(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S0;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and Mealy flag; the flag fires only on the closing 1 from S2 or S3
  always_comb begin
    state_next_s = state_r;
    z            = 1'b0;
    case (state_r)
      S0: begin
        if (sig_to_test) state_next_s = S0;
        else             state_next_s = S1;
      end
      S1: begin
        if (sig_to_test) state_next_s = S2;
        else             state_next_s = S1;
      end
      S2: begin
        if (sig_to_test) begin
          state_next_s = S0;
          z            = 1'b1;
        end else begin
          state_next_s = S3;
        end
      end
      S3: begin
        if (sig_to_test) begin
          state_next_s = S2;
          z            = 1'b1;
        end else begin
          state_next_s = S3;
        end
      end
      default: begin
        state_next_s = S0;
        z            = 1'b0;
      end
    endcase
  end

  // Two-digit BCD detection counter, wraps 99 -> 00
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ones_r <= 4'd0;
      tens_r <= 4'd0;
    end else if (z && ena) begin
      if (ones_r == 4'd9) begin
        ones_r <= 4'd0;
        if (tens_r == 4'd9) tens_r <= 4'd0;
        else                tens_r <= tens_r + 4'd1;
      end else begin
        ones_r <= ones_r + 4'd1;
      end
    end else begin
      ones_r <= ones_r;
      tens_r <= tens_r;
    end
  end

  assign disp0 = seg7(ones_r);
  assign disp1 = seg7(tens_r);

endmodule

// File: tb/tb_sequence_detector.sv
// Directed, table-driven bench for sequence_detector: checks the Mealy flag before each edge
// and both display digits after it against a hand-computed detection count.
module tb_sequence_detector;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ena = 1'b0;
  logic       sig_to_test = 1'b0;
  logic [6:0] disp0;
  logic [6:0] disp1;
  logic       z;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  typedef struct {
    logic sig;
    logic en;
    logic exp_z;
  } vec_t;

  vec_t vecs[24];

  localparam logic [23:0] STREAM = 24'b000100110001011101010011;
  localparam logic [23:0] ZMASK  = 24'b000000110000011000010011;

  sequence_detector dut (
    .clk(clk), .rst(rst), .ena(ena), .sig_to_test(sig_to_test),
    .disp0(disp0), .disp1(disp1), .z(z)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg(input int d);
    logic [6:0] tbl [10];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return tbl[d];
  endfunction

  task automatic check7(input string name, input logic [6:0] act, input logic [6:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, req);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, req);
    end
  endtask

  task automatic check_disp(input string name);
    check7({name, " disp0"}, disp0, seg(exp_cnt % 10));
    check7({name, " disp1"}, disp1, seg(exp_cnt / 10));
  endtask

  // One bit per clock: inputs set at the falling edge, z checked before the rising edge
  task automatic step(input logic s, input logic e, input logic ez, input string name);
    @(negedge clk);
    sig_to_test = s;
    ena = e;
    #1;
    check1({name, " z"}, z, ez);
    if (ez && e) exp_cnt = (exp_cnt + 1) % 100;
    @(posedge clk);
    #1;
    check_disp(name);
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    rst = 1'b0;
    sig_to_test = 1'bx;
    exp_cnt = 0;
    #2;
    check1({name, " reset z"}, z, 1'b0);
    check_disp({name, " reset"});
    @(negedge clk);
    rst = 1'b1;
    sig_to_test = 1'b0;
  endtask

  task automatic run_011(input logic e, input string name);
    step(1'b0, e, 1'b0, name);
    step(1'b1, e, 1'b0, name);
    step(1'b1, e, 1'b1, name);
  endtask

  initial begin
    for (int i = 0; i < 24; i++) begin
      vecs[i].sig   = STREAM[23 - i];
      vecs[i].en    = 1'b1;
      vecs[i].exp_z = ZMASK[23 - i];
    end

    // Reset state, then the 24-bit stream with counting enabled
    do_reset("por");
    for (int i = 0; i < 24; i++) step(vecs[i].sig, vecs[i].en, vecs[i].exp_z, "stream_en");
    check7("stream_en final disp0", disp0, 7'b1111000);
    check7("stream_en final disp1", disp1, 7'b1000000);

    // Zero-length 0* case
    do_reset("zz");
    run_011(1'b1, "zz");
    check7("zz final disp0", disp0, 7'b1111001);

    // S3 self-loop and S3->S2 overlap
    do_reset("s3");
    step(1'b0, 1'b1, 1'b0, "s3");
    step(1'b1, 1'b1, 1'b0, "s3");
    step(1'b0, 1'b1, 1'b0, "s3");
    step(1'b0, 1'b1, 1'b0, "s3");
    step(1'b0, 1'b1, 1'b0, "s3");
    step(1'b0, 1'b1, 1'b0, "s3");
    step(1'b1, 1'b1, 1'b1, "s3");
    step(1'b1, 1'b1, 1'b1, "s3");
    check7("s3 final disp0", disp0, 7'b0100100);

    // Same stream with counting disabled: z unchanged, count holds at 00
    do_reset("stream_dis");
    for (int i = 0; i < 24; i++) step(vecs[i].sig, 1'b0, vecs[i].exp_z, "stream_dis");
    check7("stream_dis final disp0", disp0, 7'b1000000);
    check7("stream_dis final disp1", disp1, 7'b1000000);

    // 100 detections: 09->10 carry, 99, then wrap to 00
    do_reset("wrap");
    for (int n = 1; n <= 100; n++) begin
      run_011(1'b1, "wrap");
      if (n == 10) begin
        check7("carry10 disp0", disp0, 7'b1000000);
        check7("carry10 disp1", disp1, 7'b1111001);
      end
      if (n == 99) begin
        check7("cnt99 disp0", disp0, 7'b0010000);
        check7("cnt99 disp1", disp1, 7'b0010000);
      end
    end
    check7("wrap00 disp0", disp0, 7'b1000000);
    check7("wrap00 disp1", disp1, 7'b1000000);

    // Asynchronous mid-cycle reset with FSM parked in S2
    do_reset("async");
    run_011(1'b1, "async");
    run_011(1'b1, "async");
    run_011(1'b1, "async");
    step(1'b0, 1'b1, 1'b0, "async pre");
    step(1'b1, 1'b1, 1'b0, "async pre");
    @(negedge clk);
    sig_to_test = 1'b1;
    #1;
    check1("async S2 armed z", z, 1'b1);
    #1;
    rst = 1'b0;
    #1;
    exp_cnt = 0;
    check1("async z after rst", z, 1'b0);
    check_disp("async immediate");
    @(negedge clk);
    rst = 1'b1;
    sig_to_test = 1'b0;
    run_011(1'b1, "async after");
    check7("async after disp0", disp0, 7'b1111001);
    check7("async after disp1", disp1, 7'b1000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
